// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU field constants, status encoding and decoder enums
// Purpose: single source for the FPU word layout (sign [31], exp [30:25],
//   mant [24:0], bias 31), the one-hot status vocabulary shared with the adder,
//   and the float-to-int decoder state/class enums.
// Ports: none (package).
package fpu_pkg;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int BIAS   = 31;
  localparam int OUT_W  = 32;
  localparam int SIG_W  = MANT_W + 1;

  // Exponent at which {1,mant} is already the integer value (no shift).
  localparam logic [EXP_W-1:0] E_UNITY = EXP_W'(BIAS + MANT_W);
  // First exponent whose magnitude no longer fits a signed OUT_W result.
  localparam logic [EXP_W-1:0] E_SAT   = EXP_W'(BIAS + OUT_W - 1);

  typedef logic [3:0] fpu_status_t;
  localparam fpu_status_t ST_EXACT     = 4'b0001;
  localparam fpu_status_t ST_INEXACT   = 4'b0010;
  localparam fpu_status_t ST_OVERFLOW  = 4'b0100;
  localparam fpu_status_t ST_UNDERFLOW = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    SHIFT,
    DONE
  } dec_state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_UNDER,
    CLS_OVER,
    CLS_NEG_MAX,
    CLS_NORMAL
  } dec_class_t;

  localparam logic [OUT_W-1:0] INT_MAX    = 32'h7FFF_FFFF;
  localparam logic [OUT_W-1:0] INT_MIN    = 32'h8000_0000;
  // -2^31 is representable exactly, so it escapes the overflow class.
  localparam logic [OUT_W-1:0] NEG_MAX_OP = 32'hFC00_0000;

  function automatic logic [OUT_W-1:0] sat_value(input logic sign);
    return sign ? INT_MIN : INT_MAX;
  endfunction

endpackage

// File: rtl/fpu_dec_classify.sv
// rtl/fpu_dec_classify.sv - combinational special-case classifier for float-to-int
// Purpose: inspects the registered operand and reports its class, the shift
//   direction and the shift count |e - 56| for the in-range path.
//   Optional macro: FPU_DEC_ROUND_NEAREST_EN lowers the underflow threshold
//   so that |v| in [0.5,1) takes the shift path and can round up to 1.
// Ports:
//   op         in  32  registered float operand
//   cls        out     special-case class
//   shift_left out  1  1 = shift left (e > 56), 0 = shift right
//   cnt        out  6  shift distance; only meaningful for CLS_NORMAL
module fpu_dec_classify
  import fpu_pkg::*;
(
  input  logic [OUT_W-1:0] op,
  output dec_class_t       cls,
  output logic             shift_left,
  output logic [EXP_W-1:0] cnt
);

`ifdef FPU_DEC_ROUND_NEAREST_EN
  localparam logic [EXP_W-1:0] E_LOW = EXP_W'(BIAS - 1);
`else
  localparam logic [EXP_W-1:0] E_LOW = EXP_W'(BIAS);
`endif

  logic [EXP_W-1:0]  e;
  logic [MANT_W-1:0] mant;

  assign e    = op[OUT_W-2 -: EXP_W];
  assign mant = op[MANT_W-1:0];

  always_comb begin
    shift_left = (e > E_UNITY);
    cnt        = (e > E_UNITY) ? (e - E_UNITY) : (E_UNITY - e);
    cls        = CLS_NORMAL;
    if (e == '0 && mant == '0) begin
      cls = CLS_ZERO;
    end else if (e < E_LOW) begin
      cls = CLS_UNDER;
    end else if (op == NEG_MAX_OP) begin
      cls = CLS_NEG_MAX;
    end else if (e >= E_SAT) begin
      cls = CLS_OVER;
    end
  end

endmodule

// File: rtl/fpu_float_to_int.sv
// rtl/fpu_float_to_int.sv - iterative float-to-signed-int decoder with valid/ready
// Purpose: converts an FPU-format word into a signed 32-bit integer using a
//   one-bit-per-cycle shifter, truncating toward zero, and reports one-hot
//   status (EXACT, INEXACT, OVERFLOW, UNDERFLOW).
//   Optional macro: FPU_DEC_ROUND_NEAREST_EN switches right shifts to
//   round-to-nearest-even using a guard bit plus sticky.
// Ports:
//   clock100KHz in   1  clock, rising edge
//   reset       in   1  asynchronous active-low reset
//   op_in       in  32  float operand
//   in_valid    in   1  op_in valid
//   in_ready    out  1  idle and accepting
//   data_out    out 32  signed result, held after handoff
//   status_out  out  4  one-hot status, held after handoff
//   flags_out   out  1  status is not EXACT
//   out_valid   out  1  result valid
//   out_ready   in   1  consumer accepts result
module fpu_float_to_int
  import fpu_pkg::*;
(
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic [OUT_W-1:0] op_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] data_out,
  output logic [3:0]       status_out,
  output logic             flags_out,
  output logic             out_valid,
  input  logic             out_ready
);

  dec_state_t        state_q, state_d;
  logic [OUT_W-1:0]  op_q, op_d;
  dec_class_t        cls_q, cls_d;
  logic              left_q, left_d;
  logic [EXP_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  mag_q, mag_d;
  logic              sticky_q, sticky_d;
  logic [OUT_W-1:0]  data_q, data_d;
  fpu_status_t       status_q, status_d;
  logic              flags_q, flags_d;
  logic              out_valid_q, out_valid_d;
`ifdef FPU_DEC_ROUND_NEAREST_EN
  logic              guard_q, guard_d;
`endif

  dec_class_t        cls_c;
  logic              left_c;
  logic [EXP_W-1:0]  cnt_c;

  logic [OUT_W-1:0]  res_mag;
  logic              res_inexact;
  logic              res_carry;
  logic              sign;

  assign sign = op_q[OUT_W-1];

  fpu_dec_classify u_classify (
    .op         (op_q),
    .cls        (cls_c),
    .shift_left (left_c),
    .cnt        (cnt_c)
  );

  // Final magnitude before negation; rounding happens here so the sign is
  // applied to an already-rounded value.
  always_comb begin
    res_mag     = mag_q;
    res_inexact = sticky_q;
    res_carry   = 1'b0;
`ifdef FPU_DEC_ROUND_NEAREST_EN
    res_mag     = mag_q + {{(OUT_W-1){1'b0}}, guard_q & (sticky_q | mag_q[0])};
    res_inexact = guard_q | sticky_q;
    res_carry   = res_mag[OUT_W-1];
`endif
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cls_d       = cls_q;
    left_d      = left_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    sticky_d    = sticky_q;
    data_d      = data_q;
    status_d    = status_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
`ifdef FPU_DEC_ROUND_NEAREST_EN
    guard_d     = guard_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op_in;
          state_d = CLASSIFY;
        end
      end

      CLASSIFY: begin
        cls_d    = cls_c;
        left_d   = left_c;
        cnt_d    = cnt_c;
        mag_d    = OUT_W'({1'b1, op_q[MANT_W-1:0]});
        sticky_d = 1'b0;
`ifdef FPU_DEC_ROUND_NEAREST_EN
        guard_d  = 1'b0;
`endif
        if (cls_c == CLS_NORMAL && cnt_c != '0) begin
          state_d = SHIFT;
        end else begin
          state_d = DONE;
        end
      end

      SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d = mag_q >> 1;
`ifdef FPU_DEC_ROUND_NEAREST_EN
          // The previous guard falls into sticky; the bit now leaving becomes guard.
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
`else
          sticky_d = sticky_q | mag_q[0];
`endif
        end
        cnt_d = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // First DONE cycle forms the result; after that everything is held
        // until the consumer takes it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          case (cls_q)
            CLS_ZERO: begin
              data_d   = '0;
              status_d = ST_EXACT;
            end
            CLS_UNDER: begin
              data_d   = '0;
              status_d = ST_UNDERFLOW;
            end
            CLS_OVER: begin
              data_d   = sat_value(sign);
              status_d = ST_OVERFLOW;
            end
            CLS_NEG_MAX: begin
              data_d   = INT_MIN;
              status_d = ST_EXACT;
            end
            default: begin
              if (res_carry) begin
                data_d   = sat_value(sign);
                status_d = sign ? ST_INEXACT : ST_OVERFLOW;
              end else begin
                data_d   = sign ? (~res_mag + OUT_W'(1)) : res_mag;
                status_d = res_inexact ? ST_INEXACT : ST_EXACT;
              end
            end
          endcase
          flags_d = (status_d != ST_EXACT);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cls_q       <= CLS_ZERO;
      left_q      <= 1'b0;
      cnt_q       <= '0;
      mag_q       <= '0;
      sticky_q    <= 1'b0;
      data_q      <= '0;
      status_q    <= '0;
      flags_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef FPU_DEC_ROUND_NEAREST_EN
      guard_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cls_q       <= cls_d;
      left_q      <= left_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      sticky_q    <= sticky_d;
      data_q      <= data_d;
      status_q    <= status_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
`ifdef FPU_DEC_ROUND_NEAREST_EN
      guard_q     <= guard_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign data_out   = data_q;
  assign status_out = status_q;
  assign flags_out  = flags_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_fpu_float_to_int.sv
// tb/tb_fpu_float_to_int.sv - directed self-checking bench for fpu_float_to_int
module tb_fpu_float_to_int;

  logic        clock100KHz = 1'b0;
  logic        reset       = 1'b1;
  logic [31:0] op_in       = '0;
  logic        in_valid    = 1'b0;
  logic        out_ready   = 1'b1;
  logic        in_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        flags_out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  fpu_float_to_int dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .op_in       (op_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .status_out  (status_out),
    .flags_out   (flags_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clock100KHz = ~clock100KHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers op for one cycle, then counts edges from the accept edge until
  // out_valid is seen (bounded).
  task automatic run_op(input logic [31:0] op, output int lat);
    @(negedge clock100KHz);
    op_in    = op;
    in_valid = 1'b1;
    @(posedge clock100KHz);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clock100KHz);
      #1;
      lat++;
    end
  endtask

  task automatic expect_op(input string tag, input logic [31:0] op,
                           input logic [31:0] exp_d, input logic [3:0] exp_st,
                           input int exp_lat);
    int lat;
    run_op(op, lat);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".data"}, data_out, exp_d);
    chk({tag, ".status"}, {28'b0, status_out}, {28'b0, exp_st});
    chk({tag, ".flags"}, {31'b0, flags_out}, {31'b0, (exp_st != 4'b0001)});
    @(posedge clock100KHz);
    #1;
    chk({tag, ".vld_drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".idle"}, {31'b0, in_ready}, 32'd1);
    chk({tag, ".held"}, data_out, exp_d);
  endtask

  initial begin
    int lat;
    logic [31:0] held_d;
    logic [3:0]  held_s;

    #1 reset = 1'b0;
    repeat (2) @(posedge clock100KHz);
    #1;
    chk("rst.data", data_out, 32'd0);
    chk("rst.status", {28'b0, status_out}, 32'd0);
    chk("rst.flags", {31'b0, flags_out}, 32'd0);
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock100KHz);
    reset = 1'b1;

    expect_op("one",      32'h3E00_0000, 32'd1,         4'b0001, 27);
`ifdef FPU_DEC_ROUND_NEAREST_EN
    expect_op("p3_5",     32'h4180_0000, 32'd4,         4'b0010, 26);
    expect_op("n3_5",     32'hC180_0000, 32'hFFFF_FFFC, 4'b0010, 26);
    expect_op("half",     32'h3C00_0000, 32'd0,         4'b0010, 28);
`else
    expect_op("p3_5",     32'h4180_0000, 32'd3,         4'b0010, 26);
    expect_op("n3_5",     32'hC180_0000, 32'hFFFF_FFFD, 4'b0010, 26);
    expect_op("half",     32'h3C00_0000, 32'd0,         4'b1000, 2);
`endif
    expect_op("ovf_pos",  32'h7C00_0000, 32'h7FFF_FFFF, 4'b0100, 2);
    expect_op("neg_max",  32'hFC00_0000, 32'h8000_0000, 4'b0001, 2);
    expect_op("ovf_neg",  32'hFC00_0001, 32'h8000_0000, 4'b0100, 2);
    expect_op("zero_p",   32'h0000_0000, 32'd0,         4'b0001, 2);
    expect_op("zero_n",   32'h8000_0000, 32'd0,         4'b0001, 2);
    expect_op("denorm",   32'h0000_0001, 32'd0,         4'b1000, 2);
    expect_op("e29",      32'h3A00_0000, 32'd0,         4'b1000, 2);
    expect_op("e56",      32'h7000_0000, 32'h0200_0000, 4'b0001, 2);
    expect_op("e56_neg",  32'hF000_0000, 32'hFE00_0000, 4'b0001, 2);
    expect_op("e61",      32'h7A00_0000, 32'h4000_0000, 4'b0001, 7);

    // Backpressure: result held for 10 cycles while a new request is offered.
    out_ready = 1'b0;
    run_op(32'h4180_0000, lat);
    chk("bp.lat", lat, 32'd26);
`ifdef FPU_DEC_ROUND_NEAREST_EN
    held_d = 32'd4;
`else
    held_d = 32'd3;
`endif
    held_s = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock100KHz);
      op_in    = 32'h7C00_0000;
      in_valid = 1'b1;
      @(posedge clock100KHz);
      #1;
      chk("bp.data", data_out, held_d);
      chk("bp.status", {28'b0, status_out}, {28'b0, held_s});
      chk("bp.valid", {31'b0, out_valid}, 32'd1);
      chk("bp.ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clock100KHz);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock100KHz);
    #1;
    chk("bp.drop", {31'b0, out_valid}, 32'd0);
    chk("bp.idle", {31'b0, in_ready}, 32'd1);
    chk("bp.held", data_out, held_d);
    repeat (3) @(posedge clock100KHz);
    #1;
    chk("bp.no_ghost", {31'b0, out_valid}, 32'd0);
    chk("bp.still_idle", {31'b0, in_ready}, 32'd1);

    // Reset in the middle of a long right shift.
    @(negedge clock100KHz);
    op_in    = 32'h3E00_0000;
    in_valid = 1'b1;
    @(posedge clock100KHz);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock100KHz);
    @(negedge clock100KHz);
    reset = 1'b0;
    #1;
    chk("mid_rst.data", data_out, 32'd0);
    chk("mid_rst.status", {28'b0, status_out}, 32'd0);
    chk("mid_rst.flags", {31'b0, flags_out}, 32'd0);
    chk("mid_rst.valid", {31'b0, out_valid}, 32'd0);
    @(negedge clock100KHz);
    reset = 1'b1;
    #1;
    chk("mid_rst.idle", {31'b0, in_ready}, 32'd1);
    expect_op("after_rst", 32'h4080_0000, 32'd2, 4'b0010, 26);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
